// File: rtl/skin_blob_locator.sv
// Reduces a thresholded skin/background pixel stream to one report per frame:
// foreground pixel count, inclusive bounding box and floor centroid.
module skin_blob_locator #(
    parameter int BIN_LAG   = 1,
    parameter int MIN_COUNT = 64
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iBinary,
    input  logic        iDVAL,
    input  logic [15:0] iX_Cont,
    input  logic [15:0] iY_Cont,
    input  logic        iFrame_En,
    output logic        oValid,
    output logic        oFound,
    output logic [10:0] oCentX,
    output logic [10:0] oCentY,
    output logic [10:0] oMinX,
    output logic [10:0] oMaxX,
    output logic [10:0] oMinY,
    output logic [10:0] oMaxY,
    output logic [21:0] oCount,
    output logic        oBusy,
    output logic        oDrop
);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;

    localparam logic [21:0] MIN_CNT  = 22'(MIN_COUNT);
    localparam logic [10:0] COORD_HI = 11'd2047;

    state_t      state, nextState;
    logic        dv, fe;
    logic [10:0] x, y;

    // The aligned frame enable resets high so a frame already in progress at
    // reset release never looks like a rising edge and cannot arm a report.
    generate
        if (BIN_LAG != 0) begin : gLag
            logic        dvR, feR;
            logic [10:0] xR, yR;
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    dvR <= 1'b0;
                    feR <= 1'b1;
                    xR  <= '0;
                    yR  <= '0;
                end else begin
                    dvR <= iDVAL;
                    feR <= iFrame_En;
                    xR  <= iX_Cont[11:1];
                    yR  <= iY_Cont[11:1];
                end
            end
            assign dv = dvR;
            assign fe = feR;
            assign x  = xR;
            assign y  = yR;
        end else begin : gNoLag
            assign dv = iDVAL;
            assign fe = iFrame_En;
            assign x  = iX_Cont[11:1];
            assign y  = iY_Cont[11:1];
        end
    endgenerate

    logic feQ, armed;
    logic feRise, feFall, frameEnd, qual, found;

    assign feRise   = fe & ~feQ;
    assign feFall   = feQ & ~fe;
    assign frameEnd = feFall & armed;
    assign qual     = dv & fe & iBinary;

    logic [21:0] accCount;
    logic [32:0] accSumX, accSumY;
    logic [10:0] accMinX, accMaxX, accMinY, accMaxY;

    assign found = (accCount >= MIN_CNT);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            feQ   <= 1'b1;
            armed <= 1'b0;
        end else begin
            feQ <= fe;
            if (feRise)
                armed <= 1'b1;
        end
    end

    // A rising edge that coincides with a foreground pixel starts the frame at that pixel.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST || 1'b0) begin
            accCount <= '0;
            accSumX  <= '0;
            accSumY  <= '0;
            accMinX  <= COORD_HI;
            accMaxX  <= '0;
            accMinY  <= COORD_HI;
            accMaxY  <= '0;
        end else if (feFall || (feRise && !qual)) begin
            accCount <= '0;
            accSumX  <= '0;
            accSumY  <= '0;
            accMinX  <= COORD_HI;
            accMaxX  <= '0;
            accMinY  <= COORD_HI;
            accMaxY  <= '0;
        end else if (feRise) begin
            accCount <= 22'd1;
            accSumX  <= {22'd0, x};
            accSumY  <= {22'd0, y};
            accMinX  <= x;
            accMaxX  <= x;
            accMinY  <= y;
            accMaxY  <= y;
        end else if (qual) begin
            accCount <= accCount + 22'd1;
            accSumX  <= accSumX + {22'd0, x};
            accSumY  <= accSumY + {22'd0, y};
            if (x < accMinX) accMinX <= x;
            if (x > accMaxX) accMaxX <= x;
            if (y < accMinY) accMinY <= y;
            if (y > accMaxY) accMaxY <= y;
        end
    end

    // Two restoring dividers sharing the snapshot count as divisor.
    logic [21:0] snapCount, remX, remY;
    logic [32:0] quoX, quoY, quoNextX, quoNextY;
    logic [22:0] remShX, remShY, remNextX, remNextY;
    logic        geX, geY;
    logic [10:0] snapMinX, snapMaxX, snapMinY, snapMaxY;
    logic [5:0]  iter;

    assign remShX   = {remX, quoX[32]};
    assign remShY   = {remY, quoY[32]};
    assign geX      = (remShX >= {1'b0, snapCount});
    assign geY      = (remShY >= {1'b0, snapCount});
    assign remNextX = geX ? remShX - {1'b0, snapCount} : remShX;
    assign remNextY = geY ? remShY - {1'b0, snapCount} : remShY;
    assign quoNextX = {quoX[31:0], geX};
    assign quoNextY = {quoY[31:0], geY};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    // NOTE: defaulting nextState before the case keeps this block free of latches.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (frameEnd) nextState = found ? S_DIV : S_OUT;
            S_DIV:   if (iter == 6'd32) nextState = S_OUT;
            S_OUT:   nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            snapCount <= '0;
            snapMinX  <= '0;
            snapMaxX  <= '0;
            snapMinY  <= '0;
            snapMaxY  <= '0;
            quoX      <= '0;
            quoY      <= '0;
            remX      <= '0;
            remY      <= '0;
            iter      <= '0;
            oFound    <= 1'b0;
            oCount    <= '0;
            oCentX    <= '0;
            oCentY    <= '0;
            oMinX     <= '0;
            oMaxX     <= '0;
            oMinY     <= '0;
            oMaxY     <= '0;
        end else begin
            if (state == S_IDLE && frameEnd) begin
                if (found) begin
                    snapCount <= accCount;
                    snapMinX  <= accMinX;
                    snapMaxX  <= accMaxX;
                    snapMinY  <= accMinY;
                    snapMaxY  <= accMaxY;
                    quoX      <= accSumX;
                    quoY      <= accSumY;
                    remX      <= '0;
                    remY      <= '0;
                    iter      <= '0;
                end else begin
                    oFound <= 1'b0;
                    oCount <= accCount;
                    oCentX <= '0;
                    oCentY <= '0;
                    oMinX  <= '0;
                    oMaxX  <= '0;
                    oMinY  <= '0;
                    oMaxY  <= '0;
                end
            end
            if (state == S_DIV) begin
                quoX <= quoNextX;
                quoY <= quoNextY;
                remX <= remNextX[21:0];
                remY <= remNextY[21:0];
                iter <= iter + 6'd1;
                // The last iteration's quotient goes straight into the outputs.
                if (iter == 6'd32) begin
                    oFound <= 1'b1;
                    oCount <= snapCount;
                    oCentX <= quoNextX[10:0];
                    oCentY <= quoNextY[10:0];
                    oMinX  <= snapMinX;
                    oMaxX  <= snapMaxX;
                    oMinY  <= snapMinY;
                    oMaxY  <= snapMaxY;
                end
            end
        end
    end

    assign oValid = (state == S_OUT);
    assign oBusy  = (state == S_DIV);
    assign oDrop  = frameEnd & (state != S_IDLE);

    logic unusedBits;
    assign unusedBits = ^{iX_Cont[15:12], iX_Cont[0], iY_Cont[15:12], iY_Cont[0],
                          remNextX[22], remNextY[22]};

endmodule

// File: tb/tb_skin_blob_locator.sv
// Directed bench for skin_blob_locator (BIN_LAG=1, MIN_COUNT=4) with
// hand-computed report values and latencies measured from the frame-end cycle.
module tb_skin_blob_locator;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iBinary, iDVAL, iFrame_En;
    logic [15:0] iX_Cont, iY_Cont;
    logic        oValid, oFound, oBusy, oDrop;
    logic [10:0] oCentX, oCentY, oMinX, oMaxX, oMinY, oMaxY;
    logic [21:0] oCount;

    skin_blob_locator #(.BIN_LAG(1), .MIN_COUNT(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iBinary(iBinary), .iDVAL(iDVAL),
        .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFrame_En(iFrame_En),
        .oValid(oValid), .oFound(oFound), .oCentX(oCentX), .oCentY(oCentY),
        .oMinX(oMinX), .oMaxX(oMaxX), .oMinY(oMinY), .oMaxY(oMaxY),
        .oCount(oCount), .oBusy(oBusy), .oDrop(oDrop)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0, errors = 0;
    int cyc = 0;
    int validCnt = 0, validCyc = -1, dropCnt = 0, dropCyc = -1;
    int eCyc, e1, e2, v0, d0;
    logic binQ = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        if (oValid) begin
            validCnt++;
            validCyc = cyc;
        end
        if (oDrop) begin
            dropCnt++;
            dropCyc = cyc;
        end
    end

    // Drives one cycle; iBinary carries the previous call's pixel value.
    task automatic setIn(input logic dv, input logic fe, input logic [10:0] x,
                         input logic [10:0] y, input logic bin);
        iDVAL     = dv;
        iFrame_En = fe;
        iX_Cont   = {4'd0, x, 1'b0};
        iY_Cont   = {4'd0, y, 1'b0};
        iBinary   = binQ;
        binQ      = bin;
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) setIn(1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
    endtask

    // Leaves the bench in cycle E (aligned frame enable just fell).
    task automatic endFrame();
        setIn(1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
        eCyc = cyc;
    endtask

    task automatic checkReport(input string tag, input int lat, input logic fnd,
                               input int cnt, input int cx, input int cy,
                               input int x0, input int x1, input int y0, input int y1);
        check({tag, "_nvalid"}, validCnt - v0, 1);
        check({tag, "_lat"}, validCyc - eCyc, lat);
        check({tag, "_found"}, oFound, fnd);
        check({tag, "_count"}, oCount, cnt);
        check({tag, "_centx"}, oCentX, cx);
        check({tag, "_centy"}, oCentY, cy);
        check({tag, "_bbox"}, {oMinX, oMaxX, oMinY, oMaxY},
              {11'(x0), 11'(x1), 11'(y0), 11'(y1)});
    endtask

    initial begin
        iRST = 1'b1;
        iDVAL = 1'b0; iFrame_En = 1'b1; iBinary = 1'b0;
        iX_Cont = '0; iY_Cont = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_valid", oValid, 0);
        check("rst_found", oFound, 0);
        check("rst_busy", oBusy, 0);
        check("rst_drop", oDrop, 0);
        check("rst_count", oCount, 0);
        check("rst_cent", {oCentX, oCentY}, 0);
        check("rst_bbox", {oMinX, oMaxX, oMinY, oMaxY}, 0);
        iRST = 1'b0;

        // Frame already running at reset release: its end must not report.
        for (int i = 0; i < 6; i++) setIn(1'b1, 1'b1, 11'(i), 11'(i), 1'b1);
        endFrame();
        idle(40);
        check("unarmed_no_report", validCnt, 0);

        // 4x4 blob at X 10..13, Y 20..23 inside an 8x8 scan.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        for (int yy = 18; yy <= 25; yy++)
            for (int xx = 8; xx <= 15; xx++)
                setIn(1'b1, 1'b1, 11'(xx), 11'(yy),
                      (xx >= 10 && xx <= 13 && yy >= 20 && yy <= 23));
        endFrame();
        v0 = validCnt;
        setIn(1'b0, 1'b0, 11'd0, 11'd0, 1'b0);
        check("blob_busy", oBusy, 1);
        idle(40);
        check("blob_idle_busy", oBusy, 0);
        checkReport("blob", 34, 1'b1, 16, 11, 21, 10, 13, 20, 23);

        // Three foreground pixels: below threshold, immediate report.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        for (int i = 1; i <= 3; i++) setIn(1'b1, 1'b1, 11'(i), 11'(i), 1'b1);
        setIn(1'b1, 1'b1, 11'd9, 11'd9, 1'b0);
        endFrame();
        v0 = validCnt;
        idle(5);
        checkReport("small", 1, 1'b0, 3, 0, 0, 0, 0, 0, 0);
        idle(10);
        check("small_hold_count", oCount, 3);

        // Skin everywhere but no pixel qualifier.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b1);
        for (int i = 0; i < 8; i++) setIn(1'b0, 1'b1, 11'(i), 11'(i), 1'b1);
        endFrame();
        v0 = validCnt;
        idle(5);
        checkReport("nodval", 1, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        // Frame enable high for a single cycle.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        endFrame();
        v0 = validCnt;
        idle(5);
        checkReport("zerolen", 1, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        // Second frame ends during the first frame's division.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        setIn(1'b1, 1'b1, 11'd100, 11'd50, 1'b1);
        setIn(1'b1, 1'b1, 11'd101, 11'd50, 1'b1);
        setIn(1'b1, 1'b1, 11'd100, 11'd51, 1'b1);
        setIn(1'b1, 1'b1, 11'd101, 11'd51, 1'b1);
        endFrame();
        e1 = eCyc;
        v0 = validCnt;
        d0 = dropCnt;
        idle(2);
        for (int i = 0; i < 10; i++) setIn(1'b1, 1'b1, 11'(i), 11'd0, 1'b1);
        endFrame();
        e2 = eCyc;
        idle(40);
        check("drop_pulses", dropCnt - d0, 1);
        check("drop_cycle", dropCyc - e2, 0);
        eCyc = e1;
        checkReport("first", 34, 1'b1, 4, 100, 50, 100, 101, 50, 51);

        // Reset in the middle of a frame, then one full frame.
        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        for (int i = 0; i < 5; i++) setIn(1'b1, 1'b1, 11'(i), 11'(i), 1'b1);
        iRST = 1'b1;
        setIn(1'b1, 1'b1, 11'd3, 11'd3, 1'b1);
        setIn(1'b1, 1'b1, 11'd3, 11'd3, 1'b1);
        iRST = 1'b0;
        for (int i = 0; i < 5; i++) setIn(1'b1, 1'b1, 11'(i), 11'(i), 1'b1);
        endFrame();
        v0 = validCnt;
        idle(40);
        check("rstmid_no_report", validCnt - v0, 0);

        setIn(1'b0, 1'b1, 11'd0, 11'd0, 1'b0);
        repeat (100) setIn(1'b1, 1'b1, 11'd5, 11'd7, 1'b1);
        endFrame();
        v0 = validCnt;
        idle(40);
        checkReport("after_rst", 34, 1'b1, 100, 5, 7, 5, 5, 7, 7);
        check("drop_total", dropCnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
